bus_src_fifo: RTL and testbench

BUS_SRC_FIFO -- requirements
Module: bus_src_fifo

---
 rtl/bus_src_fifo.sv | 89 ++++++++
 tb/tb_bus_src_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_src_fifo.sv
// rtl/bus_src_fifo.sv - first-word fall-through packet FIFO feeding a bus source
module bus_src_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8,
  parameter int cnt_w   = $clog2(depth) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               pop,
  output logic [pckg_sz-1:0] D_pop,
  output logic               pndng,
  output logic               full,
  output logic [cnt_w-1:0]   count,
  output logic               overflow,
  output logic               underflow,
  output logic [7:0]         drop_cnt
);

  localparam int aw = $clog2(depth);
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth);
  localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);
  localparam logic [aw-1:0]    ptr_one = aw'(1);

  logic [pckg_sz-1:0] mem [depth];
  logic [aw-1:0]      wr_ptr;
  logic [aw-1:0]      rd_ptr;

  logic is_empty;
  logic is_full;
  logic do_push;
  logic do_pop;
  logic rej_push;

  // Accept decisions: a pop on a full FIFO frees the slot for a same-cycle push,
  // while a pop on an empty FIFO is ignored even when a push arrives with it.
  always_comb begin
    is_empty = (count == '0);
    is_full  = (count == depth_c);
    do_pop   = pop && !is_empty;
    do_push  = push && (!is_full || do_pop);
    rej_push = push && is_full && !pop;
  end

  // Status and head-of-queue view, all derived from registered state.
  always_comb begin
    pndng = !is_empty;
    full  = is_full;
    D_pop = is_empty ? '0 : mem[rd_ptr];
  end

  // Packet storage; contents are left alone by reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= D_push;
    end
  end

  // Pointers, occupancy, error pulses and the saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ptr_one;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ptr_one;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase
      overflow  <= rej_push;
      underflow <= pop && is_empty;
      if (rej_push && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_src_fifo.sv
// tb/tb_bus_src_fifo.sv - scoreboard bench for bus_src_fifo
module tb_bus_src_fifo;

  localparam int PW = 16;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic [PW-1:0] D_push = '0;
  logic          pop = 1'b0;
  logic [PW-1:0] D_pop;
  logic          pndng;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;
  logic [7:0]    drop_cnt;

  bus_src_fifo #(.pckg_sz(PW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop),
    .D_pop(D_pop), .pndng(pndng), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  logic [PW-1:0] sb[$];
  int            m_drop = 0;
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;
  logic          pop_taken = 1'b0;
  logic [PW-1:0] obs_pop = '0;
  logic [PW-1:0] exp_pop = '0;

  // One clock of stimulus; the model decides acceptance, queues expected
  // packets, and captures the head the DUT shows when a pop is accepted.
  task automatic step(input logic p, input logic [PW-1:0] d, input logic r, input logic rs);
    logic m_empty, m_full, pop_ok, push_ok;
    push = p; D_push = d; pop = r; reset = rs;
    m_empty = (sb.size() == 0);
    m_full  = (sb.size() == DEPTH);
    pop_ok  = r && !m_empty;
    push_ok = p && (!m_full || pop_ok);
    pop_taken = 1'b0;
    if (rs) begin
      sb.delete();
      m_drop = 0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      exp_ovf = p && m_full && !r;
      exp_udf = r && m_empty;
      if (pop_ok) begin
        pop_taken = 1'b1;
        obs_pop = D_pop;
        exp_pop = sb.pop_front();
      end
      if (push_ok) sb.push_back(d);
      if (exp_ovf && m_drop < 255) m_drop++;
    end
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    total++; if (count !== '0) $display("FAIL reset_count got %0d want 0", count); else passed++;
    total++; if (pndng !== 1'b0) $display("FAIL reset_pndng got %b want 0", pndng); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else passed++;
    total++; if (D_pop !== '0) $display("FAIL reset_dpop got %h want 0", D_pop); else passed++;
    total++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop got %0d want 0", drop_cnt); else passed++;
    total++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_flags got %b want 00", {overflow, underflow}); else passed++;
  endtask

  task automatic test_basic();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0A11, 1'b0, 1'b0);
    total++; if (pndng !== 1'b1) $display("FAIL basic_pndng got %b want 1", pndng); else passed++;
    total++; if (D_pop !== 16'h0A11) $display("FAIL basic_head1 got %h want 0a11", D_pop); else passed++;
    step(1'b1, 16'hFF22, 1'b0, 1'b0);
    total++; if (count !== CW'(2)) $display("FAIL basic_count2 got %0d want 2", count); else passed++;
    total++; if (D_pop !== 16'h0A11) $display("FAIL basic_head2 got %h want 0a11", D_pop); else passed++;
    step(1'b0, '0, 1'b1, 1'b0);
    total++; if (!pop_taken || obs_pop !== exp_pop) $display("FAIL basic_pop1 got %h want %h", obs_pop, exp_pop); else passed++;
    total++; if (D_pop !== 16'hFF22) $display("FAIL basic_head3 got %h want ff22", D_pop); else passed++;
    total++; if (count !== CW'(1)) $display("FAIL basic_count1 got %0d want 1", count); else passed++;
    step(1'b0, '0, 1'b1, 1'b0);
    total++; if (obs_pop !== 16'hFF22) $display("FAIL basic_pop2 got %h want ff22", obs_pop); else passed++;
    total++; if (pndng !== 1'b0 || D_pop !== '0) $display("FAIL basic_empty got pndng=%b d=%h want 0/0", pndng, D_pop); else passed++;
  endtask

  task automatic test_fill_overflow();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, PW'(16'h0100 + i), 1'b0, 1'b0);
    total++; if (full !== 1'b1 || count !== CW'(8)) $display("FAIL fill_full got full=%b count=%0d want 1/8", full, count); else passed++;
    step(1'b1, 16'h0108, 1'b0, 1'b0);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_pulse got %b want 1", overflow); else passed++;
    total++; if (drop_cnt !== 8'd1) $display("FAIL ovf_drop got %0d want 1", drop_cnt); else passed++;
    total++; if (count !== CW'(8)) $display("FAIL ovf_count got %0d want 8", count); else passed++;
    step(1'b0, '0, 1'b0, 1'b0);
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      total++;
      if (!pop_taken || obs_pop !== exp_pop || obs_pop !== PW'(16'h0100 + i))
        $display("FAIL fill_drain%0d got %h want %h", i, obs_pop, PW'(16'h0100 + i));
      else passed++;
    end
    total++; if (pndng !== 1'b0) $display("FAIL fill_empty got %b want 0", pndng); else passed++;
  endtask

  task automatic test_full_push_pop();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, PW'(16'h0200 + i), 1'b0, 1'b0);
    step(1'b1, 16'h0555, 1'b1, 1'b0);
    total++; if (count !== CW'(8) || full !== 1'b1) $display("FAIL fpp_count got %0d want 8", count); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL fpp_ovf got %b want 0", overflow); else passed++;
    total++; if (obs_pop !== 16'h0200) $display("FAIL fpp_pop got %h want 0200", obs_pop); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      total++; if (!pop_taken || obs_pop !== exp_pop) $display("FAIL fpp_drain%0d got %h want %h", i, obs_pop, exp_pop); else passed++;
    end
    total++; if (obs_pop !== 16'h0555) $display("FAIL fpp_last got %h want 0555", obs_pop); else passed++;
  endtask

  task automatic test_underflow();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    total++; if (underflow !== exp_udf || underflow !== 1'b1) $display("FAIL udf_pulse got %b want 1", underflow); else passed++;
    total++; if (count !== '0) $display("FAIL udf_count got %0d want 0", count); else passed++;
    step(1'b0, '0, 1'b0, 1'b0);
    total++; if (underflow !== 1'b0) $display("FAIL udf_clear got %b want 0", underflow); else passed++;
    step(1'b1, 16'h0333, 1'b1, 1'b0);
    total++; if (count !== CW'(1)) $display("FAIL udf_pp_count got %0d want 1", count); else passed++;
    total++; if (D_pop !== 16'h0333) $display("FAIL udf_pp_head got %h want 0333", D_pop); else passed++;
    total++; if (underflow !== 1'b1) $display("FAIL udf_pp_pulse got %b want 1", underflow); else passed++;
  endtask

  task automatic test_drop_saturate();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, PW'(16'hFFA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 16'hDEAD, 1'b0, 1'b0);
      if (i == 99) begin
        total++; if (drop_cnt !== 8'd100) $display("FAIL drop_100 got %0d want 100", drop_cnt); else passed++;
      end
      if (i == 254) begin
        total++; if (drop_cnt !== 8'd255) $display("FAIL drop_255 got %0d want 255", drop_cnt); else passed++;
      end
    end
    total++; if (drop_cnt !== 8'(m_drop) || drop_cnt !== 8'd255) $display("FAIL drop_sat got %0d want 255", drop_cnt); else passed++;
    total++; if (D_pop !== 16'hFFA0) $display("FAIL drop_head got %h want ffa0", D_pop); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      total++; if (obs_pop !== exp_pop) $display("FAIL mid_drain%0d got %h want %h", i, obs_pop, exp_pop); else passed++;
    end
    total++; if (count !== CW'(5)) $display("FAIL mid_count5 got %0d want 5", count); else passed++;
    step(1'b1, 16'h1234, 1'b1, 1'b1);
    total++; if (count !== '0 || pndng !== 1'b0) $display("FAIL mid_rst_count got %0d/%b want 0/0", count, pndng); else passed++;
    total++; if (D_pop !== '0) $display("FAIL mid_rst_dpop got %h want 0", D_pop); else passed++;
    total++; if (drop_cnt !== 8'd0) $display("FAIL mid_rst_drop got %0d want 0", drop_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    logic p, r;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      p = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      step(p, PW'($urandom), r, 1'b0);
      if (pop_taken) begin
        total++; if (obs_pop !== exp_pop) $display("FAIL b2b_data%0d got %h want %h", i, obs_pop, exp_pop); else passed++;
      end
      total++;
      if (count !== CW'(sb.size()) || overflow !== exp_ovf || underflow !== exp_udf || drop_cnt !== 8'(m_drop))
        $display("FAIL b2b_state%0d got c=%0d o=%b u=%b d=%0d want c=%0d o=%b u=%b d=%0d",
                 i, count, overflow, underflow, drop_cnt, sb.size(), exp_ovf, exp_udf, m_drop);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_push_pop();
    test_underflow();
    test_drop_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
